multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL take parameter OP_W, default 4, width of op_type (legal range 4..8).
REQ-002 The block SHALL take parameter TIMEOUT, default 16, maximum consecutive cycles a memory wait may last (legal range 1..255).
REQ-003 The block SHALL have port clk  input  1  single clock, all state changes on rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous active-high reset.
REQ-005 The block SHALL have port op_type  input  OP_W  opcode class from decoder.
REQ-006 The block SHALL have port reg_imm  input  1  1 = I-type (immediate operand).
REQ-007 The block SHALL have port zero  input  1  ALU zero flag, sampled in EXECUTE.
REQ-008 The block SHALL have port mem_ready  input  1  memory handshake, 1 = current access completes this cycle.
REQ-009 The block SHALL have outputs ir_write, pc_write, pc_src, alu_src_b, mem_re, mem_we, mem_to_reg, reg_write, halted, fault, each output 1 bit, plus state_o output 3 bits (current state code).

Function
REQ-010 The block SHALL decode op_type[3:0]: 0-7 ALU, 8 LOAD, 9 STORE, 10 BRANCH, 11 JUMP, 12 HALT, 13-15 illegal; any nonzero op_type[OP_W-1:4] SHALL be illegal.
REQ-011 The block SHALL latch the decoded class and reg_imm on the DECODE cycle; op_type/reg_imm changes after DECODE SHALL have no effect on the current instruction.
REQ-012 States and codes SHALL be FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, HALT=5; state_o SHALL equal the current code; codes 6-7 SHALL go to FETCH next cycle.
REQ-013 FETCH: mem_re=1, ir_write=1; stay while mem_ready=0; on mem_ready=1 assert pc_write=1 (pc_src=0) that cycle and go to DECODE.
REQ-014 DECODE: all outputs 0; HALT class -> HALT; illegal -> FETCH; else -> EXECUTE.
REQ-015 EXECUTE: alu_src_b = latched reg_imm; ALU -> WRITEBACK; LOAD/STORE -> MEM.
REQ-016 EXECUTE with BRANCH: pc_src=1, pc_write=zero; JUMP: pc_src=1, pc_write=1; both -> FETCH.
REQ-017 MEM: LOAD asserts mem_re=1, STORE asserts mem_we=1, held every cycle until mem_ready=1; on completion LOAD -> WRITEBACK, STORE -> FETCH.
REQ-018 WRITEBACK: reg_write=1 for exactly one cycle, mem_to_reg=1 if LOAD else 0; -> FETCH.
REQ-019 HALT: halted=1, all other strobes 0; remain until rst.
REQ-020 A wait counter SHALL count consecutive mem_ready=0 cycles in FETCH or MEM and clear on leaving the state or on mem_ready=1.
REQ-021 When the counter reaches TIMEOUT with mem_ready still 0, the next state SHALL be HALT and fault SHALL set (sticky until rst); no pc_write/reg_write SHALL occur for the aborted access.
REQ-022 mem_ready=1 on the same cycle the counter reaches TIMEOUT SHALL complete the access normally (ready wins).
REQ-023 All strobe outputs SHALL be combinational from state and latched class; mem_we and reg_write SHALL never be asserted in the same cycle.
REQ-024 Latency with mem_ready tied 1: ALU 4 cycles, LOAD 5, STORE 4, BRANCH/JUMP 3, illegal 2.

Reset
REQ-025 rst=1 SHALL immediately force state FETCH, wait counter 0, latched class ALU, reg_imm 0, fault 0, halted 0.
REQ-026 While rst=1 all outputs other than state_o SHALL be 0 (mem_re/ir_write gated) and state_o=0.
REQ-027 rst asserted mid-instruction (any state, including mid-wait) SHALL abandon it with no further strobes; first FETCH follows the first clk edge after release.

Verification
REQ-028 mem_ready=1, op_type=3, reg_imm=1 -> state_o 0,1,2,4,0; alu_src_b=1 in EXECUTE; one reg_write pulse in WRITEBACK.
REQ-029 op_type=8, mem_ready low 3 cycles in MEM -> mem_re held 4 cycles, then WRITEBACK with mem_to_reg=1, reg_write=1.
REQ-030 op_type=10 with zero=0 then zero=1 -> pc_write=0 then pc_write=1 with pc_src=1 in EXECUTE; both return to FETCH after 3 cycles.
REQ-031 TIMEOUT=4, STORE, mem_ready held 0 -> mem_we 4 cycles, then state_o=5, halted=1, fault=1 until rst.
REQ-032 op_type=14, then op_type=12 -> illegal returns to FETCH after DECODE with no strobes; HALT enters state 5, halted=1.
REQ-033 rst pulse asynchronously mid-MEM of a STORE -> mem_we drops without waiting for clk, state_o=0, fault=0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for a multicycle RISC-V style datapath.
// Sequences fetch/decode/execute/mem/writeback with a memory wait timeout.
module multicycle_ctrl #(
   parameter int OP_W    = 4,
   parameter int TIMEOUT = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [OP_W-1:0] op_type,
   input  logic            reg_imm,
   input  logic            zero,
   input  logic            mem_ready,
   output logic            ir_write,
   output logic            pc_write,
   output logic            pc_src,
   output logic            alu_src_b,
   output logic            mem_re,
   output logic            mem_we,
   output logic            mem_to_reg,
   output logic            reg_write,
   output logic            halted,
   output logic            fault,
   output logic [2:0]      state_o
);

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;
   localparam logic [2:0] S_HALT   = 3'd5;

   localparam logic [2:0] C_ALU   = 3'd0;
   localparam logic [2:0] C_LOAD  = 3'd1;
   localparam logic [2:0] C_STORE = 3'd2;
   localparam logic [2:0] C_BR    = 3'd3;
   localparam logic [2:0] C_JMP   = 3'd4;
   localparam logic [2:0] C_HALT  = 3'd5;
   localparam logic [2:0] C_ILL   = 3'd6;

   // Last tolerated wait count; one more idle cycle aborts the access.
   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   logic [2:0] state_q, state_d;
   logic [2:0] cls_q, cls_d, dec_cls;
   logic       imm_q, imm_d;
   logic       fault_q, fault_d;
   logic [7:0] wait_q, wait_d;
   logic [7:0] op_ext;
   logic [3:0] op_lo;
   logic       op_hi;
   logic       timed_out;

   // Classify the incoming opcode; any upper bit set makes it illegal.
   always_comb begin
      op_ext  = 8'(op_type);
      op_lo   = op_ext[3:0];
      op_hi   = |op_ext[7:4];
      dec_cls = C_ILL;
      unique case (1'b1)
         (!op_hi && !op_lo[3]):       dec_cls = C_ALU;
         (!op_hi && op_lo == 4'd8):   dec_cls = C_LOAD;
         (!op_hi && op_lo == 4'd9):   dec_cls = C_STORE;
         (!op_hi && op_lo == 4'd10):  dec_cls = C_BR;
         (!op_hi && op_lo == 4'd11):  dec_cls = C_JMP;
         (!op_hi && op_lo == 4'd12):  dec_cls = C_HALT;
         default:                     dec_cls = C_ILL;
      endcase
   end

   assign timed_out = !mem_ready && (wait_q == WAIT_LAST);

   // Next-state, wait counter, class latch and sticky fault.
   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      cls_d   = cls_q;
      imm_d   = imm_q;
      fault_d = fault_q;
      case (state_q)
         S_FETCH: begin
            if (mem_ready) begin
               state_d = S_DECODE;
               wait_d  = '0;
            end else if (timed_out) begin
               state_d = S_HALT;
               wait_d  = '0;
               fault_d = 1'b1;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end
         S_DECODE: begin
            cls_d = dec_cls;
            imm_d = reg_imm;
            if (dec_cls == C_HALT)
               state_d = S_HALT;
            else if (dec_cls == C_ILL)
               state_d = S_FETCH;
            else
               state_d = S_EXEC;
         end
         S_EXEC: begin
            if (cls_q == C_ALU)
               state_d = S_WB;
            else if (cls_q == C_LOAD || cls_q == C_STORE)
               state_d = S_MEM;
            else
               state_d = S_FETCH;
         end
         S_MEM: begin
            if (mem_ready) begin
               state_d = (cls_q == C_LOAD) ? S_WB : S_FETCH;
               wait_d  = '0;
            end else if (timed_out) begin
               state_d = S_HALT;
               wait_d  = '0;
               fault_d = 1'b1;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end
         S_WB:    state_d = S_FETCH;
         S_HALT:  state_d = S_HALT;
         default: begin
            state_d = S_FETCH;
            wait_d  = '0;
         end
      endcase
   end

   // State registers; reset abandons any instruction in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_FETCH;
         wait_q  <= '0;
         cls_q   <= C_ALU;
         imm_q   <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         cls_q   <= cls_d;
         imm_q   <= imm_d;
         fault_q <= fault_d;
      end
   end

   // Strobes from state and latched class, all held low during reset.
   always_comb begin
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      alu_src_b  = 1'b0;
      mem_re     = 1'b0;
      mem_we     = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      halted     = 1'b0;
      if (!rst) begin
         case (state_q)
            S_FETCH: begin
               mem_re   = 1'b1;
               ir_write = 1'b1;
               pc_write = mem_ready;
            end
            S_EXEC: begin
               alu_src_b = imm_q;
               if (cls_q == C_BR) begin
                  pc_src   = 1'b1;
                  pc_write = zero;
               end else if (cls_q == C_JMP) begin
                  pc_src   = 1'b1;
                  pc_write = 1'b1;
               end
            end
            S_MEM: begin
               mem_re = (cls_q == C_LOAD);
               mem_we = (cls_q == C_STORE);
            end
            S_WB: begin
               reg_write  = 1'b1;
               mem_to_reg = (cls_q == C_LOAD);
            end
            S_HALT:  halted = 1'b1;
            default: ;
         endcase
      end
   end

   assign fault   = fault_q;
   assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed checks of the multicycle control FSM.
// Runs with TIMEOUT=4 so memory wait aborts are reachable quickly.
module tb_multicycle_ctrl;

   localparam logic [9:0] IRW = 10'h200;
   localparam logic [9:0] PCW = 10'h100;
   localparam logic [9:0] PCS = 10'h080;
   localparam logic [9:0] ASB = 10'h040;
   localparam logic [9:0] MRE = 10'h020;
   localparam logic [9:0] MWE = 10'h010;
   localparam logic [9:0] MTR = 10'h008;
   localparam logic [9:0] RGW = 10'h004;
   localparam logic [9:0] HLT = 10'h002;
   localparam logic [9:0] FLT = 10'h001;
   localparam logic [9:0] NON = 10'h000;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] op_type;
   logic       reg_imm;
   logic       zero;
   logic       mem_ready;
   logic       ir_write, pc_write, pc_src, alu_src_b;
   logic       mem_re, mem_we, mem_to_reg, reg_write;
   logic       halted, fault;
   logic [2:0] state_o;

   int total = 0;
   int bad   = 0;

   multicycle_ctrl #(
      .OP_W(4),
      .TIMEOUT(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .op_type(op_type),
      .reg_imm(reg_imm),
      .zero(zero),
      .mem_ready(mem_ready),
      .ir_write(ir_write),
      .pc_write(pc_write),
      .pc_src(pc_src),
      .alu_src_b(alu_src_b),
      .mem_re(mem_re),
      .mem_we(mem_we),
      .mem_to_reg(mem_to_reg),
      .reg_write(reg_write),
      .halted(halted),
      .fault(fault),
      .state_o(state_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [2:0] es,
                      input logic [9:0] eo);
      logic [12:0] got;
      logic [12:0] exp;
      #1;
      got = {state_o, ir_write, pc_write, pc_src, alu_src_b, mem_re,
             mem_we, mem_to_reg, reg_write, halted, fault};
      exp = {es, eo};
      total++;
      assert (got === exp)
      else begin
         bad++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   initial begin
      rst = 1'b1;
      op_type = 4'd0;
      reg_imm = 1'b0;
      zero = 1'b0;
      mem_ready = 1'b0;
      chk("rst0", 3'd0, NON);
      tick();
      chk("rst1", 3'd0, NON);

      // ALU op, immediate; inputs changed after DECODE are ignored
      rst = 1'b0;
      mem_ready = 1'b1;
      op_type = 4'd3;
      reg_imm = 1'b1;
      chk("alu_f", 3'd0, IRW | MRE | PCW);
      tick();
      chk("alu_d", 3'd1, NON);
      tick();
      op_type = 4'd9;
      reg_imm = 1'b0;
      chk("alu_e", 3'd2, ASB);
      tick();
      chk("alu_wb", 3'd4, RGW);
      tick();

      // LOAD with three idle cycles in MEM, ready on the boundary cycle
      op_type = 4'd8;
      reg_imm = 1'b0;
      chk("ld_f", 3'd0, IRW | MRE | PCW);
      tick();
      chk("ld_d", 3'd1, NON);
      tick();
      chk("ld_e", 3'd2, NON);
      tick();
      mem_ready = 1'b0;
      chk("ld_m0", 3'd3, MRE);
      tick();
      chk("ld_m1", 3'd3, MRE);
      tick();
      chk("ld_m2", 3'd3, MRE);
      tick();
      mem_ready = 1'b1;
      chk("ld_m3", 3'd3, MRE);
      tick();
      chk("ld_wb", 3'd4, MTR | RGW);
      tick();

      // BRANCH not taken, then taken
      op_type = 4'd10;
      zero = 1'b0;
      chk("br0_f", 3'd0, IRW | MRE | PCW);
      tick();
      tick();
      chk("br0_e", 3'd2, PCS);
      tick();
      zero = 1'b1;
      chk("br1_f", 3'd0, IRW | MRE | PCW);
      tick();
      tick();
      chk("br1_e", 3'd2, PCS | PCW);
      tick();

      // JUMP with immediate operand
      op_type = 4'd11;
      reg_imm = 1'b1;
      zero = 1'b0;
      tick();
      tick();
      chk("jmp_e", 3'd2, PCS | PCW | ASB);
      tick();

      // illegal opcode drops back to FETCH after DECODE
      op_type = 4'd14;
      reg_imm = 1'b0;
      chk("ill_f", 3'd0, IRW | MRE | PCW);
      tick();
      chk("ill_d", 3'd1, NON);
      tick();
      chk("ill_r", 3'd0, IRW | MRE | PCW);

      // STORE times out in MEM after four idle cycles
      op_type = 4'd9;
      tick();
      tick();
      chk("st_e", 3'd2, NON);
      tick();
      mem_ready = 1'b0;
      chk("st_m0", 3'd3, MWE);
      tick();
      chk("st_m1", 3'd3, MWE);
      tick();
      chk("st_m2", 3'd3, MWE);
      tick();
      chk("st_m3", 3'd3, MWE);
      tick();
      chk("st_to", 3'd5, HLT | FLT);
      mem_ready = 1'b1;
      tick();
      chk("st_hold", 3'd5, HLT | FLT);
      rst = 1'b1;
      chk("st_rst", 3'd0, NON);
      tick();

      // HALT opcode parks the FSM without a fault
      rst = 1'b0;
      op_type = 4'd12;
      chk("h_f", 3'd0, IRW | MRE | PCW);
      tick();
      chk("h_d", 3'd1, NON);
      tick();
      chk("h_s", 3'd5, HLT);
      tick();
      chk("h_hold", 3'd5, HLT);

      // async reset in the middle of a STORE wait
      rst = 1'b1;
      tick();
      rst = 1'b0;
      op_type = 4'd9;
      mem_ready = 1'b1;
      chk("s2_f", 3'd0, IRW | MRE | PCW);
      tick();
      tick();
      tick();
      mem_ready = 1'b0;
      chk("s2_m0", 3'd3, MWE);
      tick();
      chk("s2_m1", 3'd3, MWE);
      #1;
      rst = 1'b1;
      chk("s2_rst", 3'd0, NON);

      // FETCH wait also times out; no pc_write on the aborted fetch
      rst = 1'b0;
      chk("fw_0", 3'd0, IRW | MRE);
      tick();
      chk("fw_1", 3'd0, IRW | MRE);
      tick();
      chk("fw_2", 3'd0, IRW | MRE);
      tick();
      chk("fw_3", 3'd0, IRW | MRE);
      tick();
      chk("fw_to", 3'd5, HLT | FLT);
      rst = 1'b1;
      chk("fw_rst", 3'd0, NON);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
